// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//    Bundles every handshake and bus signal that passes through
//    mem_port_arbiter. The three sides are the instruction-fetch requester
//    (i_*), the load/store requester (d_*) and the single physical memory
//    port (mem_*).
//
// Modports:
//    slave  - arbiter view. It receives requests and memory responses, and it
//             drives requester responses and the memory strobes.
//    master - environment view (CPU requesters plus the memory model). It is
//             the mirror image of slave.
//
// Signals:
//    i_read, i_address            instruction read request, held until i_resp
//    i_rdata, i_resp              instruction read data and one-cycle pulse
//    d_read, d_write              data read/write request, held until d_resp
//    d_byte_enable, d_address,
//    d_wdata                      data request payload
//    d_rdata, d_resp              data read data and one-cycle pulse
//    mem_read, mem_write          memory strobes
//    mem_byte_enable, mem_address,
//    mem_wdata                    memory request payload
//    mem_rdata, mem_resp          memory read data and one-cycle completion
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   // Instruction side
   logic                  i_read;
   logic [ADDR_W-1:0]     i_address;
   logic [DATA_W-1:0]     i_rdata;
   logic                  i_resp;

   // Data side
   logic                  d_read;
   logic                  d_write;
   logic [DATA_W/8-1:0]   d_byte_enable;
   logic [ADDR_W-1:0]     d_address;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W-1:0]     d_rdata;
   logic                  d_resp;

   // Physical memory port
   logic                  mem_read;
   logic                  mem_write;
   logic [DATA_W/8-1:0]   mem_byte_enable;
   logic [ADDR_W-1:0]     mem_address;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;
   logic                  mem_resp;

   modport slave (
      input  i_read, i_address,
      output i_rdata, i_resp,
      input  d_read, d_write, d_byte_enable, d_address, d_wdata,
      output d_rdata, d_resp,
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      input  mem_rdata, mem_resp
   );

   modport master (
      output i_read, i_address,
      input  i_rdata, i_resp,
      output d_read, d_write, d_byte_enable, d_address, d_wdata,
      input  d_rdata, d_resp,
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      output mem_rdata, mem_resp
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//    Shares one word-wide memory port between the instruction-fetch requester
//    and the load/store requester. Only one request is in flight at a time.
//    The granted request is captured into the mem_* registers and held there
//    until memory answers. The read data and a one-cycle response pulse are
//    then returned to the side that owned the transaction.
//
// Ports:
//    clk  - rising-edge clock
//    rst  - asynchronous, active-low reset (asserted when 0)
//    bus  - mem_port_arbiter_if.slave carrying the i_*, d_* and mem_* signals
//
// Parameters:
//    ADDR_W - address width in bits
//    DATA_W - data width in bits (byte-enable width is DATA_W/8)
//
// Configuration macro:
//    MEM_PORT_ARBITER_RR_EN
//       undefined - fixed priority: any data request beats an instruction read.
//       defined   - round robin: when both sides are pending, the side that
//                   was not granted last wins. A lone requester always wins.
//
// Sequencing:
//    IDLE - choose a winner, load mem_*, raise the strobe, go to BUSY
//    BUSY - hold mem_*; on mem_resp drop the strobe, return the data, pulse
//           the owner's resp, go to DONE
//    DONE - drop resp and skip sampling the requesters, because they still
//           show the request that just completed; go back to IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_INST = 1'b0,
      OWNER_DATA = 1'b1
   } owner_t;

   state_t state;
   owner_t owner;

`ifdef MEM_PORT_ARBITER_RR_EN
   owner_t last_grant;
`endif

   logic              d_req;
   logic              i_req;
   logic              any_req;
   logic              grant_data;
   logic              win_write;
   logic [ADDR_W-1:0] win_address;
   logic [DATA_W-1:0] win_wdata;
   logic [BE_W-1:0]   win_byte_enable;

   // Arbitration. A data request is a read, a write or both. When both
   // d_read and d_write are set, the request is treated as a write. In
   // round-robin mode a tie goes to the side that was not granted last.
   // Otherwise the data side wins any tie.
   always_comb begin
      d_req   = bus.d_read | bus.d_write;
      i_req   = bus.i_read;
      any_req = d_req | i_req;
`ifdef MEM_PORT_ARBITER_RR_EN
      if (d_req && i_req) begin
         grant_data = (last_grant == OWNER_INST);
      end else begin
         grant_data = d_req;
      end
`else
      grant_data = d_req;
`endif
   end

   // Build the request that IDLE will capture. Reads always present a full
   // byte-enable mask. The instruction side has no write data, so zero is
   // driven in its place.
   always_comb begin
      win_write       = 1'b0;
      win_address     = bus.i_address;
      win_wdata       = '0;
      win_byte_enable = {BE_W{1'b1}};
      if (grant_data) begin
         win_write   = bus.d_write;
         win_address = bus.d_address;
         win_wdata   = bus.d_wdata;
         if (bus.d_write) begin
            win_byte_enable = bus.d_byte_enable;
         end
      end
   end

   // Main controller. All outputs are registered here so that memory and the
   // requesters see clean, glitch-free signals. An asynchronous reset drops
   // the strobes immediately. No response is ever produced for a transaction
   // that a reset interrupts, because the response registers are cleared and
   // the state returns to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= IDLE;
         owner               <= OWNER_INST;
`ifdef MEM_PORT_ARBITER_RR_EN
         last_grant          <= OWNER_DATA;
`endif
         bus.mem_read        <= 1'b0;
         bus.mem_write       <= 1'b0;
         bus.mem_byte_enable <= '0;
         bus.mem_address     <= '0;
         bus.mem_wdata       <= '0;
         bus.i_rdata         <= '0;
         bus.i_resp          <= 1'b0;
         bus.d_rdata         <= '0;
         bus.d_resp          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner               <= grant_data ? OWNER_DATA : OWNER_INST;
`ifdef MEM_PORT_ARBITER_RR_EN
                  last_grant          <= grant_data ? OWNER_DATA : OWNER_INST;
`endif
                  bus.mem_address     <= win_address;
                  bus.mem_wdata       <= win_wdata;
                  bus.mem_byte_enable <= win_byte_enable;
                  bus.mem_write       <= win_write;
                  bus.mem_read        <= ~win_write;
                  state               <= BUSY;
               end
            end

            BUSY: begin
               // mem_* stay frozen and requester inputs are ignored until
               // memory completes. Write responses also load rdata; that
               // value is meaningless to the requester.
               if (bus.mem_resp) begin
                  bus.mem_read  <= 1'b0;
                  bus.mem_write <= 1'b0;
                  if (owner == OWNER_DATA) begin
                     bus.d_rdata <= bus.mem_rdata;
                     bus.d_resp  <= 1'b1;
                  end else begin
                     bus.i_rdata <= bus.mem_rdata;
                     bus.i_resp  <= 1'b1;
                  end
                  state <= DONE;
               end
            end

            DONE: begin
               bus.i_resp <= 1'b0;
               bus.d_resp <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               bus.mem_read  <= 1'b0;
               bus.mem_write <= 1'b0;
               bus.i_resp    <= 1'b0;
               bus.d_resp    <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. The bench drives inputs and
// samples outputs 1 time unit after each rising clock edge. Every scenario
// task does its own comparisons against hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic clk;
   logic rst;

   int total;
   int bad;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends on its own
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus.i_read = 1'b1; bus.i_address = 32'h0000_0010;
      bus.d_write = 1'b1; bus.d_address = 32'h0000_0020;
      bus.d_wdata = 32'hFFFF_FFFF; bus.d_byte_enable = 4'hF;
      tick; tick;
      total++; if (bus.mem_read !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_read got=%0h exp=0", bus.mem_read); end
      total++; if (bus.mem_write !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_write got=%0h exp=0", bus.mem_write); end
      total++; if (bus.mem_address !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_address got=%0h exp=0", bus.mem_address); end
      total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_wdata got=%0h exp=0", bus.mem_wdata); end
      total++; if (bus.mem_byte_enable !== 4'h0) begin bad++; $display("[TB] FAIL reset_mem_be got=%0h exp=0", bus.mem_byte_enable); end
      total++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin bad++; $display("[TB] FAIL reset_resp got=%0b exp=00", {bus.i_resp, bus.d_resp}); end
      total++; if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%0h exp=0", {bus.i_rdata, bus.d_rdata}); end
      // Release with only the instruction side requesting
      bus.d_write = 1'b0;
      bus.i_address = 32'h0000_0060;
      rst = 1'b1;
      tick;
      total++; if (bus.mem_read !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_mem_read got=%0h exp=1", bus.mem_read); end
      total++; if (bus.mem_address !== 32'h0000_0060) begin bad++; $display("[TB] FAIL post_reset_mem_address got=%0h exp=60", bus.mem_address); end
      bus.mem_rdata = 32'h0000_00A5; bus.mem_resp = 1'b1;
      tick;
      total++; if (bus.i_resp !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_i_resp got=%0h exp=1", bus.i_resp); end
      bus.mem_resp = 1'b0; bus.i_read = 1'b0;
      tick; tick;
   endtask

   task automatic test_inst_read;
      bus.i_read = 1'b1; bus.i_address = 32'h0000_0200;
      tick;
      total++; if (bus.mem_read !== 1'b1) begin bad++; $display("[TB] FAIL iread_strobe got=%0h exp=1", bus.mem_read); end
      total++; if (bus.mem_byte_enable !== 4'hF) begin bad++; $display("[TB] FAIL iread_be got=%0h exp=f", bus.mem_byte_enable); end
      tick; tick;
      total++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin bad++; $display("[TB] FAIL iread_early_resp got=%0b exp=00", {bus.i_resp, bus.d_resp}); end
      bus.mem_rdata = 32'hDEAD_BEEF; bus.mem_resp = 1'b1;
      tick;
      total++; if (bus.i_resp !== 1'b1) begin bad++; $display("[TB] FAIL iread_resp got=%0h exp=1", bus.i_resp); end
      total++; if (bus.i_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL iread_rdata got=%0h exp=deadbeef", bus.i_rdata); end
      total++; if (bus.d_resp !== 1'b0) begin bad++; $display("[TB] FAIL iread_d_resp got=%0h exp=0", bus.d_resp); end
      total++; if (bus.mem_read !== 1'b0) begin bad++; $display("[TB] FAIL iread_strobe_drop got=%0h exp=0", bus.mem_read); end
      bus.mem_resp = 1'b0; bus.i_read = 1'b0; bus.mem_rdata = 32'h0;
      tick;
      total++; if (bus.i_resp !== 1'b0) begin bad++; $display("[TB] FAIL iread_resp_width got=%0h exp=0", bus.i_resp); end
      total++; if (bus.i_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL iread_rdata_hold got=%0h exp=deadbeef", bus.i_rdata); end
      tick;
   endtask

   task automatic test_data_write;
      bus.d_write = 1'b1; bus.d_address = 32'h0000_0100;
      bus.d_wdata = 32'h1234_5678; bus.d_byte_enable = 4'b0011;
      for (int c = 0; c < 3; c++) begin
         tick;
         total++; if ({bus.mem_write, bus.mem_read} !== 2'b10) begin bad++; $display("[TB] FAIL dwrite_strobe c%0d got=%0b exp=10", c, {bus.mem_write, bus.mem_read}); end
         total++; if (bus.mem_address !== 32'h100) begin bad++; $display("[TB] FAIL dwrite_addr c%0d got=%0h exp=100", c, bus.mem_address); end
         total++; if (bus.mem_wdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL dwrite_wdata c%0d got=%0h exp=12345678", c, bus.mem_wdata); end
         total++; if (bus.mem_byte_enable !== 4'b0011) begin bad++; $display("[TB] FAIL dwrite_be c%0d got=%0h exp=3", c, bus.mem_byte_enable); end
      end
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h0BAD_0BAD;
      tick;
      total++; if (bus.d_resp !== 1'b1) begin bad++; $display("[TB] FAIL dwrite_resp got=%0h exp=1", bus.d_resp); end
      total++; if (bus.mem_write !== 1'b0) begin bad++; $display("[TB] FAIL dwrite_strobe_drop got=%0h exp=0", bus.mem_write); end
      total++; if (bus.i_resp !== 1'b0) begin bad++; $display("[TB] FAIL dwrite_i_resp got=%0h exp=0", bus.i_resp); end
      total++; if (bus.i_rdata !== 32'hDEAD_BEEF) begin bad++; $display("[TB] FAIL dwrite_i_rdata_hold got=%0h exp=deadbeef", bus.i_rdata); end
      bus.mem_resp = 1'b0; bus.d_write = 1'b0;
      tick;
      total++; if (bus.d_resp !== 1'b0) begin bad++; $display("[TB] FAIL dwrite_resp_width got=%0h exp=0", bus.d_resp); end
      tick;
   endtask

   task automatic test_read_write_mix;
      // Both d_read and d_write set: must behave as a write with the given mask
      bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_address = 32'h0000_0140;
      bus.d_wdata = 32'hCAFE_F00D; bus.d_byte_enable = 4'b0101;
      tick;
      total++; if ({bus.mem_write, bus.mem_read} !== 2'b10) begin bad++; $display("[TB] FAIL rw_both_strobe got=%0b exp=10", {bus.mem_write, bus.mem_read}); end
      total++; if (bus.mem_byte_enable !== 4'b0101) begin bad++; $display("[TB] FAIL rw_both_be got=%0h exp=5", bus.mem_byte_enable); end
      bus.mem_resp = 1'b1; tick;
      bus.mem_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; tick; tick;
      // A plain data read ignores the byte enables and reads the full word
      bus.d_read = 1'b1; bus.d_address = 32'h0000_0180; bus.d_byte_enable = 4'b0010;
      tick;
      total++; if ({bus.mem_write, bus.mem_read} !== 2'b01) begin bad++; $display("[TB] FAIL dread_strobe got=%0b exp=01", {bus.mem_write, bus.mem_read}); end
      total++; if (bus.mem_byte_enable !== 4'hF) begin bad++; $display("[TB] FAIL dread_be got=%0h exp=f", bus.mem_byte_enable); end
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h5555_AAAA; tick;
      total++; if (bus.d_rdata !== 32'h5555_AAAA) begin bad++; $display("[TB] FAIL dread_rdata got=%0h exp=5555aaaa", bus.d_rdata); end
      bus.mem_resp = 1'b0; bus.d_read = 1'b0; tick; tick;
   endtask

   // Serves one already-pending request. The first tick is the IDLE grant
   // edge, and the state is DONE->IDLE ready for the next grant on return.
   task automatic serve(input string tag, input bit exp_data, input logic [31:0] rdata);
      logic [31:0] exp_addr;
      exp_addr = exp_data ? bus.d_address : bus.i_address;
      tick;
      total++; if (bus.mem_address !== exp_addr) begin bad++; $display("[TB] FAIL %s_grant_addr got=%0h exp=%0h", tag, bus.mem_address, exp_addr); end
      bus.mem_resp = 1'b1; bus.mem_rdata = rdata;
      tick;
      total++; if ({bus.d_resp, bus.i_resp} !== (exp_data ? 2'b10 : 2'b01)) begin bad++; $display("[TB] FAIL %s_resp_side got=%0b exp=%0b", tag, {bus.d_resp, bus.i_resp}, (exp_data ? 2'b10 : 2'b01)); end
      total++; if ((exp_data ? bus.d_rdata : bus.i_rdata) !== rdata) begin bad++; $display("[TB] FAIL %s_rdata got=%0h exp=%0h", tag, (exp_data ? bus.d_rdata : bus.i_rdata), rdata); end
      bus.mem_resp = 1'b0;
      if (exp_data) bus.d_read = 1'b0; else bus.i_read = 1'b0;
      tick;
   endtask

   task automatic test_arbitration;
      bit first_data;
`ifdef MEM_PORT_ARBITER_RR_EN
      first_data = 1'b0;
`else
      first_data = 1'b1;
`endif
      bus.i_address = 32'h0000_0400;
      bus.d_address = 32'h0000_0800;
      for (int p = 0; p < 4; p++) begin
         bus.i_read = 1'b1; bus.d_read = 1'b1;
         serve($sformatf("arb_pair%0d_first", p), first_data, 32'h1000_0000 + p);
         serve($sformatf("arb_pair%0d_second", p), !first_data, 32'h2000_0000 + p);
      end
      tick;
      total++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin bad++; $display("[TB] FAIL arb_idle_strobe got=%0b exp=00", {bus.mem_read, bus.mem_write}); end
   endtask

   task automatic test_spurious_resp;
      // mem_resp during IDLE with nothing pending
      bus.mem_resp = 1'b1; tick;
      bus.mem_resp = 1'b0;
      total++; if ({bus.i_resp, bus.d_resp, bus.mem_read} !== 3'b000) begin bad++; $display("[TB] FAIL idle_resp_ignored got=%0b exp=000", {bus.i_resp, bus.d_resp, bus.mem_read}); end
      // A request afterwards still gets a normal strobe, so no state changed
      bus.d_read = 1'b1; bus.d_address = 32'h0000_0300;
      tick;
      total++; if (bus.mem_read !== 1'b1) begin bad++; $display("[TB] FAIL idle_resp_state got=%0h exp=1", bus.mem_read); end
      // Change requester inputs during BUSY
      bus.d_address = 32'h0000_0999; bus.i_read = 1'b1; bus.i_address = 32'h0000_0777;
      tick;
      total++; if (bus.mem_address !== 32'h0000_0300) begin bad++; $display("[TB] FAIL busy_addr_stable got=%0h exp=300", bus.mem_address); end
      bus.i_read = 1'b0;
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h0000_3333;
      tick;
      total++; if (bus.d_resp !== 1'b1) begin bad++; $display("[TB] FAIL busy_d_resp got=%0h exp=1", bus.d_resp); end
      // Keep mem_resp high into DONE; it must not produce a second pulse
      bus.d_read = 1'b0;
      tick;
      total++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin bad++; $display("[TB] FAIL done_resp_ignored got=%0b exp=00", {bus.i_resp, bus.d_resp}); end
      bus.mem_resp = 1'b0;
      tick;
      total++; if ({bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write} !== 4'b0000) begin bad++; $display("[TB] FAIL done_state got=%0b exp=0000", {bus.i_resp, bus.d_resp, bus.mem_read, bus.mem_write}); end
   endtask

   task automatic test_reset_busy;
      bus.i_read = 1'b1; bus.i_address = 32'h0000_0500;
      tick;
      total++; if (bus.mem_read !== 1'b1) begin bad++; $display("[TB] FAIL rbusy_strobe got=%0h exp=1", bus.mem_read); end
      #2 rst = 1'b0;
      #1;
      total++; if (bus.mem_read !== 1'b0) begin bad++; $display("[TB] FAIL rbusy_async_drop got=%0h exp=0", bus.mem_read); end
      bus.i_read = 1'b0;
      tick;
      rst = 1'b1;
      bus.mem_resp = 1'b1; bus.mem_rdata = 32'h7777_7777;
      tick;
      bus.mem_resp = 1'b0;
      total++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin bad++; $display("[TB] FAIL rbusy_no_resp got=%0b exp=00", {bus.i_resp, bus.d_resp}); end
      total++; if (bus.i_rdata !== 32'h0) begin bad++; $display("[TB] FAIL rbusy_rdata got=%0h exp=0", bus.i_rdata); end
      bus.i_read = 1'b1; bus.i_address = 32'h0000_0540;
      tick;
      total++; if ({bus.mem_read, bus.mem_address} !== {1'b1, 32'h0000_0540}) begin bad++; $display("[TB] FAIL rbusy_idle_after got=%0h exp=100000540", {bus.mem_read, bus.mem_address}); end
      bus.mem_resp = 1'b1; tick;
      bus.mem_resp = 1'b0; bus.i_read = 1'b0; tick; tick;
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b0;
      bus.i_read = 1'b0; bus.i_address = '0;
      bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_byte_enable = '0;
      bus.d_address = '0; bus.d_wdata = '0;
      bus.mem_rdata = '0; bus.mem_resp = 1'b0;
      test_reset;
      test_inst_read;
      test_data_write;
      test_read_write_mix;
      test_arbitration;
      test_spurious_resp;
      test_reset_busy;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port (read/write/resp handshake, word-wide) between an instruction requester and a data requester.
- Sits between the CPU's instruction-fetch path, its load/store path, and the memory model/cache.
- Grants one requester at a time and holds the request in registers until memory responds.
- Returns read data and a one-cycle response pulse to the owning requester.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; byte-enable width is DATA_W/8

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (asserted when 0)
i_read  in  1  instruction read request; held until i_resp
i_address  in  ADDR_W  instruction address
i_rdata  out  DATA_W  instruction read data; valid with i_resp
i_resp  out  1  one-cycle completion pulse to instruction side
d_read  in  1  data read request; held until d_resp
d_write  in  1  data write request; held until d_resp
d_byte_enable  in  DATA_W/8  data write byte enables
d_address  in  ADDR_W  data address
d_wdata  in  DATA_W  data write data
d_rdata  out  DATA_W  data read data; valid with d_resp
d_resp  out  1  one-cycle completion pulse to data side
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_byte_enable  out  DATA_W/8  memory byte enables
mem_address  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_resp  in  1  memory completion; one-cycle pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, owner=INST, last_grant=DATA; all outputs 0 (mem_* strobes, address, wdata, byte_enable, i/d_rdata, i/d_resp).
- Reset mid-transaction: memory strobes drop immediately; no response is issued for the aborted transaction.
- All outputs are registered.
- State IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select the winner per the arbitration policy.
  - Latch the winner's address, wdata and byte_enable into the mem_* registers and set owner.
  - Set mem_read or mem_write at the same edge; move to BUSY.
  - mem_byte_enable is forced to all-ones for reads.
- State BUSY:
  - mem_* are held stable.
  - The arbiter ignores requester-input changes while in BUSY.
  - On mem_resp=1: clear mem_read/mem_write and load mem_rdata into the owner's rdata register (writes also load it; the value is don't-care).
  - Assert the owner's resp for exactly one cycle; move to DONE.
- State DONE:
  - resp deasserts.
  - Requester inputs are not sampled in this cycle, because the requester still shows the completed request.
  - Move to IDLE.
- mem_resp outside BUSY is ignored.
- Latency:
  - Request high at edge 0 (IDLE) → mem strobe visible after edge 0.
  - mem_resp sampled at edge N → resp visible after edge N for one cycle.
  - Arbiter is back in IDLE after edge N+1.
  - Minimum request-to-resp time is 2 cycles.
- i_rdata/d_rdata hold their last value until the next response to that side.
- Simultaneous d_read and d_write: treated as a write.
- Arbitration policy (baseline): fixed priority, data over instruction. Any pending d_read/d_write beats i_read.

Optional Feature:
MEM_PORT_ARBITER_RR_EN
- Defined:
  - Round-robin arbitration. When both sides request in IDLE, the side not equal to last_grant wins.
  - last_grant updates on every grant.
  - A lone requester always wins.
  - Each side is guaranteed service within one foreign transaction.
- Undefined:
  - Fixed data-over-instruction priority.
  - last_grant register is not implemented.

Test Plan:
- Reset with rst=0 while i_read=1 and d_write=1 → all outputs 0. After release with only i_read=1, addr 0x0000_0060: mem_read=1 and mem_address=0x60 one cycle later.
- Instruction read, memory responds 3 cycles after strobe with mem_rdata=0xDEAD_BEEF → i_resp=1 for exactly one cycle with i_rdata=0xDEADBEEF; d_resp stays 0.
- Data write, addr 0x100, wdata 0x1234_5678, byte_enable 4'b0011 → mem_write=1 with those values held stable until mem_resp; d_resp pulses once; mem_write=0 the cycle after mem_resp.
- i_read and d_read raised in the same cycle, macro undefined → data served first, instruction second. With the macro defined and last_grant=DATA after reset → instruction first, data second; then alternating across 4 back-to-back pairs.
- mem_resp pulsed while in IDLE and while in DONE → no resp to either side and no state change. Requester addresses changing during BUSY → mem_address unchanged.
- rst driven to 0 during BUSY → mem_read drops asynchronously. After release no resp pulse occurs and the arbiter is in IDLE.
